// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers, executes MULT/MULTU/DIV/DIVU
// with a fixed busy latency, and services MTHI/MTLO and MFHI/MFLO reads.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] rd_data
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic [31:0] divisor_safe;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] div_q_s, div_r_s, div_q_u, div_r_u;

  // Full-width products and quotients; a zero divisor is replaced by 1 so the
  // datapath never produces X, and the result is simply not committed.
  always_comb begin
    mul_s        = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    mul_u        = {32'd0, rs_val} * {32'd0, rt_val};
    divisor_safe = (rt_val == 32'd0) ? 32'd1 : rt_val;
    a_mag        = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    b_mag        = divisor_safe[31] ? (32'd0 - divisor_safe) : divisor_safe;
    q_mag        = a_mag / b_mag;
    r_mag        = a_mag % b_mag;
    div_q_s      = (rs_val[31] ^ divisor_safe[31]) ? (32'd0 - q_mag) : q_mag;
    div_r_s      = rs_val[31] ? (32'd0 - r_mag) : r_mag;
    div_q_u      = rs_val / divisor_safe;
    div_r_u      = rs_val % divisor_safe;
  end

  // Next-state logic: launch ops from IDLE, count down while BUSY, commit at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0: begin
              {pend_hi_d, pend_lo_d} = mul_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_BUSY;
            end
            3'd1: begin
              {pend_hi_d, pend_lo_d} = mul_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_BUSY;
            end
            3'd2: begin
              pend_hi_d = div_r_s;
              pend_lo_d = div_q_s;
              pend_wr_d = (rt_val != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = S_BUSY;
            end
            3'd3: begin
              pend_hi_d = div_r_u;
              pend_lo_d = div_q_u;
              pend_wr_d = (rt_val != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = S_BUSY;
            end
            3'd4: hi_d = rs_val;
            3'd5: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      default: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
    endcase
  end

  // State and register update; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Outputs read only architectural state, so pending results stay hidden.
  always_comb begin
    busy    = (state_q == S_BUSY);
    rd_data = hilo_sel ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] rd_data;

  int checks;
  int failures;
  int n;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one op for a single edge; returns at posedge+1.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 3'd7;
  endtask

  // Count edges until busy drops, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hilo_sel = 1'b1;
    #1;
    check({tag, "_hi"}, rd_data, exp_hi);
    hilo_sel = 1'b0;
    #1;
    check({tag, "_lo"}, rd_data, exp_lo);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    op       = 3'd7;
    rs_val   = '0;
    rt_val   = '0;
    hilo_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset", 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(3'd0, 32'hFFFF_FFFF, 32'd2);
    check("mult_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check_output("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    apply_stimulus(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check_output("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    apply_stimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check_output("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    apply_stimulus(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    check_output("div_negdiv", 32'd1, 32'hFFFF_FFFD);

    apply_stimulus(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_cycles", n, 32'd10);
    check_output("divu", 32'd1, 32'd3);

    apply_stimulus(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check_output("mthi", 32'h1234_5678, 32'd3);

    apply_stimulus(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    check("divz_cycles", n, 32'd10);
    check_output("divz", 32'h1234_5678, 32'd3);

    apply_stimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check_output("div_ovf", 32'h0, 32'h8000_0000);

    apply_stimulus(3'd0, 32'd3, 32'd4);
    apply_stimulus(3'd5, 32'h0000_00AA, 32'd0);
    check("ign_busy", {31'd0, busy}, 32'd1);
    check_output("during_busy", 32'h0, 32'h8000_0000);
    wait_idle(n);
    check("ign_cycles", n, 32'd4);
    check_output("ign_mtlo", 32'h0, 32'd12);

    apply_stimulus(3'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("noop_busy", {31'd0, busy}, 32'd0);
    check_output("noop", 32'h0, 32'd12);

    apply_stimulus(3'd5, 32'h0000_0055, 32'd0);
    check_output("mtlo", 32'h0, 32'h0000_0055);

    apply_stimulus(3'd0, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort", 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_after_busy", {31'd0, busy}, 32'd0);
    check_output("abort_after", 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
